// File: rtl/pipeline_mem_stage.sv
// Pipeline memory stage: issues a held load/store request and writes results to WB.
// Define MEM_ALIGN_CHECK_EN to trap misaligned word/half accesses instead of masking the address bits.
module pipeline_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_enable,
  input  logic        dmem_write_enable,
  input  logic [1:0]  dmem_type,
  input  logic [31:0] rt_data_in,
  input  logic [31:0] alu_result_in,
  input  logic [4:0]  rd_write_address_in,
  input  logic        rd_select_in,
  input  logic        rd_write_enable_in,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic [4:0]  wb_rd_write_address,
  output logic        wb_rd_select,
  output logic        wb_rd_write_enable,
  output logic        stall_out,
  output logic        align_error
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;

  logic        req_write;
  logic [31:0] req_alu;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [1:0]  req_type;
  logic [4:0]  req_rd;
  logic        req_sel;
  logic        req_we;

  logic        pend_valid;
  logic [31:0] pend_alu;
  logic [4:0]  pend_rd;
  logic        pend_sel;

  logic        sample, complete, misaligned, start_access;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [15:0] ld_half;
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [31:0] load_data;

  assign stall_out = (state_q == ACCESS) && !mem_ready;
  assign sample    = !stall_out;
  assign complete  = (state_q == ACCESS) && mem_ready;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = dmem_enable &&
                      (((dmem_type == 2'b00) && (alu_result_in[1:0] != 2'b00)) ||
                       ((dmem_type == 2'b01) && alu_result_in[0]));
`else
  assign misaligned = 1'b0;
`endif

  assign start_access = sample && dmem_enable && !misaligned;

  assign mem_req   = (state_q == ACCESS);
  assign mem_write = req_write;
  assign mem_addr  = {req_alu[31:2], 2'b00};
  assign mem_wdata = req_wdata;
  assign mem_be    = req_be;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = rt_data_in;
    case (dmem_type)
      2'b00: begin
        be_d    = 4'b1111;
        wdata_d = rt_data_in;
      end
      2'b01: begin
        be_d    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{rt_data_in[15:0]}};
      end
      default: begin
        be_d    = 4'b0001 << alu_result_in[1:0];
        wdata_d = {4{rt_data_in[7:0]}};
      end
    endcase
  end

  always_comb begin
    ld_half   = req_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_shift  = mem_rdata >> {req_alu[1:0], 3'b000};
    ld_byte   = ld_shift[7:0];
    load_data = mem_rdata;
    case (req_type)
      2'b00:   load_data = mem_rdata;
      2'b01:   load_data = {{16{ld_half[15]}}, ld_half};
      2'b10:   load_data = {{24{ld_byte[7]}}, ld_byte};
      default: load_data = {24'h0, ld_byte};
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (sample) begin
      state_d = start_access ? ACCESS : IDLE;
    end
  end

  // A register-writing ALU op sampled while a completing access owns the WB slot
  // is parked in pend_* and written on the next edge, so no op is ever dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      req_write           <= 1'b0;
      req_alu             <= '0;
      req_wdata           <= '0;
      req_be              <= '0;
      req_type            <= '0;
      req_rd              <= '0;
      req_sel             <= 1'b0;
      req_we              <= 1'b0;
      pend_valid          <= 1'b0;
      pend_alu            <= '0;
      pend_rd             <= '0;
      pend_sel            <= 1'b0;
      wb_alu_result       <= '0;
      wb_mem_data         <= '0;
      wb_rd_write_address <= '0;
      wb_rd_select        <= 1'b0;
      wb_rd_write_enable  <= 1'b0;
      align_error         <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_error <= sample && misaligned;

      if (start_access) begin
        req_write <= dmem_write_enable;
        req_alu   <= alu_result_in;
        req_wdata <= wdata_d;
        req_be    <= be_d;
        req_type  <= dmem_type;
        req_rd    <= rd_write_address_in;
        req_sel   <= rd_select_in;
        req_we    <= rd_write_enable_in;
      end

      if (!sample) begin
        wb_rd_write_enable <= 1'b0;
      end else if (complete || pend_valid) begin
        if (complete) begin
          wb_alu_result       <= req_alu;
          wb_mem_data         <= load_data;
          wb_rd_write_address <= req_rd;
          wb_rd_select        <= req_sel;
          wb_rd_write_enable  <= req_we && !req_write;
        end else begin
          wb_alu_result       <= pend_alu;
          wb_rd_write_address <= pend_rd;
          wb_rd_select        <= pend_sel;
          wb_rd_write_enable  <= 1'b1;
        end
        pend_valid <= !dmem_enable && rd_write_enable_in;
        pend_alu   <= alu_result_in;
        pend_rd    <= rd_write_address_in;
        pend_sel   <= rd_select_in;
      end else if (dmem_enable) begin
        wb_rd_write_enable <= 1'b0;
      end else begin
        wb_alu_result       <= alu_result_in;
        wb_rd_write_address <= rd_write_address_in;
        wb_rd_select        <= rd_select_in;
        wb_rd_write_enable  <= rd_write_enable_in;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Scoreboard bench for pipeline_mem_stage: directed ops push expected WB writes, a monitor pops them.
module tb_pipeline_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_enable, dmem_write_enable;
  logic [1:0]  dmem_type;
  logic [31:0] rt_data_in, alu_result_in;
  logic [4:0]  rd_write_address_in;
  logic        rd_select_in, rd_write_enable_in;
  logic        mem_req, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [4:0]  wb_rd_write_address;
  logic        wb_rd_select, wb_rd_write_enable;
  logic        stall_out, align_error;

  pipeline_mem_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .dmem_enable         (dmem_enable),
    .dmem_write_enable   (dmem_write_enable),
    .dmem_type           (dmem_type),
    .rt_data_in          (rt_data_in),
    .alu_result_in       (alu_result_in),
    .rd_write_address_in (rd_write_address_in),
    .rd_select_in        (rd_select_in),
    .rd_write_enable_in  (rd_write_enable_in),
    .mem_req             (mem_req),
    .mem_write           (mem_write),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_be              (mem_be),
    .mem_ready           (mem_ready),
    .mem_rdata           (mem_rdata),
    .wb_alu_result       (wb_alu_result),
    .wb_mem_data         (wb_mem_data),
    .wb_rd_write_address (wb_rd_write_address),
    .wb_rd_select        (wb_rd_select),
    .wb_rd_write_enable  (wb_rd_write_enable),
    .stall_out           (stall_out),
    .align_error         (align_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        sel;
    bit          chk_mem;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  logic [1:0]  vt_type [4];
  logic [31:0] vt_addr [4];
  logic [31:0] vt_rdata[4];
  logic [31:0] vt_exp  [4];
  logic [3:0]  vt_be   [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic en, input logic wr, input logic [1:0] ty,
                       input logic [31:0] rt, input logic [31:0] alu,
                       input logic [4:0] rd, input logic sel, input logic we);
    dmem_enable         = en;
    dmem_write_enable   = wr;
    dmem_type           = ty;
    rt_data_in          = rt;
    alu_result_in       = alu;
    rd_write_address_in = rd;
    rd_select_in        = sel;
    rd_write_enable_in  = we;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] rd, input logic sel, input bit chk_mem);
    exp_t e;
    e.alu = alu; e.mem = mem; e.rd = rd; e.sel = sel; e.chk_mem = chk_mem;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && wb_rd_write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got write rd=%0d alu=%h expected no write at %0t",
                 wb_rd_write_address, wb_alu_result, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_alu_result", wb_alu_result, mon_e.alu);
        chk("wb_rd_write_address", 32'(wb_rd_write_address), 32'(mon_e.rd));
        chk("wb_rd_select", 32'(wb_rd_select), 32'(mon_e.sel));
        if (mon_e.chk_mem) chk("wb_mem_data", wb_mem_data, mon_e.mem);
      end
    end
  end

  initial begin
    vt_type[0] = 2'b01; vt_addr[0] = 32'h4002; vt_rdata[0] = 32'h8001_7FFF; vt_exp[0] = 32'hFFFF_8001; vt_be[0] = 4'b1100;
    vt_type[1] = 2'b01; vt_addr[1] = 32'h4000; vt_rdata[1] = 32'h8001_7FFF; vt_exp[1] = 32'h0000_7FFF; vt_be[1] = 4'b0011;
    vt_type[2] = 2'b11; vt_addr[2] = 32'h4001; vt_rdata[2] = 32'h1234_AB56; vt_exp[2] = 32'h0000_00AB; vt_be[2] = 4'b0010;
    vt_type[3] = 2'b10; vt_addr[3] = 32'h4000; vt_rdata[3] = 32'h1234_AB56; vt_exp[3] = 32'h0000_0056; vt_be[3] = 4'b0001;

    bubble();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    #1 reset = 1'b1;
    #2;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(stall_out), 0);
    chk("rst_wb_we", 32'(wb_rd_write_enable), 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_align", 32'(align_error), 0);
    #9 reset = 1'b0;
    step();

    // ALU-only op, one-cycle latency
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h1234_5678, 5'd5, 1'b0, 1'b1);
    push(32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0);
    step();
    bubble();
    chk("nonmem_stall", 32'(stall_out), 0);
    chk("nonmem_wb_we", 32'(wb_rd_write_enable), 1);
    chk("nonmem_wb_alu", wb_alu_result, 32'h1234_5678);
    step();

    // Byte load with three wait cycles
    drive(1'b1, 1'b0, 2'b10, 32'h0, 32'h1003, 5'd7, 1'b0, 1'b1);
    push(32'h1003, 32'hFFFF_FF80, 5'd7, 1'b0, 1'b1);
    step();
    bubble();
    chk("lb_mem_req", 32'(mem_req), 1);
    chk("lb_mem_be", 32'(mem_be), 32'h8);
    chk("lb_mem_addr", mem_addr, 32'h1000);
    chk("lb_mem_write", 32'(mem_write), 0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall_wait", 32'(stall_out), 1);
      step();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'h80FF_FFFF;
    #1;
    chk("lb_stall_ready", 32'(stall_out), 0);
    chk("lb_be_held", 32'(mem_be), 32'h8);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("lb_req_drop", 32'(mem_req), 0);

    // Half store, ready immediately (ready is also high while still IDLE)
    mem_ready = 1'b1;
    drive(1'b1, 1'b1, 2'b01, 32'hAAAA_1234, 32'h2002, 5'd6, 1'b0, 1'b1);
    step();
    bubble();
    chk("sh_mem_req", 32'(mem_req), 1);
    chk("sh_mem_write", 32'(mem_write), 1);
    chk("sh_mem_be", 32'(mem_be), 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_mem_addr", mem_addr, 32'h2000);
    chk("sh_stall", 32'(stall_out), 0);
    step();
    chk("sh_wb_we", 32'(wb_rd_write_enable), 0);
    chk("sh_req_drop", 32'(mem_req), 0);

    // Back-to-back word loads
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h3000, 5'd8, 1'b0, 1'b1);
    push(32'h3000, 32'h1111_1111, 5'd8, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h3004, 5'd9, 1'b1, 1'b1);
    push(32'h3004, 32'h2222_2222, 5'd9, 1'b1, 1'b1);
    mem_rdata = 32'h1111_1111;
    chk("b2b_req_a", 32'(mem_req), 1);
    chk("b2b_addr_a", mem_addr, 32'h3000);
    step();
    bubble();
    mem_rdata = 32'h2222_2222;
    chk("b2b_req_b", 32'(mem_req), 1);
    chk("b2b_addr_b", mem_addr, 32'h3004);
    step();
    chk("b2b_req_drop", 32'(mem_req), 0);

    // Half/byte extraction table
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, vt_type[i], 32'h0, vt_addr[i], 5'(i + 20), 1'b0, 1'b1);
      push(vt_addr[i], vt_exp[i], 5'(i + 20), 1'b0, 1'b1);
      step();
      bubble();
      mem_rdata = vt_rdata[i];
      chk("ld_tbl_be", 32'(mem_be), 32'(vt_be[i]));
      step();
    end

    // ALU op arriving on the completion edge of a load: both written, in order
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h6000, 5'd10, 1'b0, 1'b1);
    push(32'h6000, 32'h0BAD_CAFE, 5'd10, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h77, 5'd11, 1'b0, 1'b1);
    push(32'h77, 32'h0, 5'd11, 1'b0, 1'b0);
    mem_rdata = 32'h0BAD_CAFE;
    step();
    bubble();
    step();
    step();

    // Asynchronous reset in the middle of an access
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'hCAFE_F00D, 5'd3, 1'b1, 1'b1);
    push(32'hCAFE_F00D, 32'h0, 5'd3, 1'b1, 1'b0);
    step();
    mem_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b10, 32'h0, 32'h5000, 5'd12, 1'b0, 1'b1);
    step();
    bubble();
    chk("rst_mid_req_before", 32'(mem_req), 1);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 0);
    chk("rst_mid_stall", 32'(stall_out), 0);
    chk("rst_mid_wb_alu", wb_alu_result, 0);
    chk("rst_mid_wb_mem", wb_mem_data, 0);
    chk("rst_mid_wb_rd", 32'(wb_rd_write_address), 0);
    chk("rst_mid_wb_sel", 32'(wb_rd_select), 0);
    chk("rst_mid_wb_we", 32'(wb_rd_write_enable), 0);
    #3 reset = 1'b0;
    step();

    // Word access at a misaligned address
`ifdef MEM_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h2, 5'd4, 1'b0, 1'b1);
    step();
    bubble();
    chk("mis_mem_req", 32'(mem_req), 0);
    chk("mis_align_pulse", 32'(align_error), 1);
    chk("mis_wb_we", 32'(wb_rd_write_enable), 0);
    chk("mis_stall", 32'(stall_out), 0);
    step();
    chk("mis_align_clear", 32'(align_error), 0);
`else
    mem_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h2, 5'd4, 1'b0, 1'b1);
    push(32'h2, 32'hDEAD_BEEF, 5'd4, 1'b0, 1'b1);
    step();
    bubble();
    mem_rdata = 32'hDEAD_BEEF;
    chk("mis_mem_addr", mem_addr, 32'h0);
    chk("mis_mem_be", 32'(mem_be), 32'hF);
    chk("mis_align", 32'(align_error), 0);
    step();
    step();
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_stage.md
PIPELINE_MEM_STAGE -- requirements
Module: pipeline_mem_stage

Interface
REQ-001 clk  input  1  sole clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 dmem_enable  input  1  EX op is a memory access.
REQ-004 dmem_write_enable  input  1  access is a store (else load).
REQ-005 dmem_type  input  2  00 word, 01 half sign-ext, 10 byte sign-ext, 11 byte zero-ext.
REQ-006 rt_data_in  input  32  store data.
REQ-007 alu_result_in  input  32  effective address / ALU result.
REQ-008 rd_write_address_in  input  5  destination register.
REQ-009 rd_select_in  input  1  WB source select, passed through.
REQ-010 rd_write_enable_in  input  1  register write request.
REQ-011 mem_req  output  1  memory request, held until mem_ready.
REQ-012 mem_write  output  1  request is a store.
REQ-013 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 mem_wdata  output  32  replicated store data.
REQ-015 mem_be  output  4  byte enables, little-endian.
REQ-016 mem_ready  input  1  request completes in this cycle.
REQ-017 mem_rdata  input  32  load data, valid when mem_ready=1.
REQ-018 wb_alu_result  output  32  registered ALU result.
REQ-019 wb_mem_data  output  32  registered, extended load data.
REQ-020 wb_rd_write_address  output  5  registered destination.
REQ-021 wb_rd_select  output  1  registered select.
REQ-022 wb_rd_write_enable  output  1  registered write enable; 0 = bubble.
REQ-023 stall_out  output  1  upstream SHALL hold its inputs when 1.
REQ-024 align_error  output  1  one-cycle misalignment pulse (REQ-040 only).

Function
REQ-025 FSM states IDLE and ACCESS; stall_out SHALL equal (state==ACCESS && !mem_ready), combinationally.
REQ-026 Inputs SHALL be sampled on every edge where stall_out=0.
REQ-027 Sampled non-memory op: wb_* SHALL update at that edge (latency 1); state stays/returns IDLE.
REQ-028 Sampled memory op: request registers load, state -> ACCESS, wb_rd_write_enable <= 0 at that edge.
REQ-029 In ACCESS, mem_req=1 and mem_write/addr/wdata/be SHALL be stable until the edge where mem_ready=1.
REQ-030 ACCESS with mem_ready=0: wb_rd_write_enable <= 0 each edge; no input sampling.
REQ-031 ACCESS with mem_ready=1: wb_* <= latched op (load data into wb_mem_data); next input sampled at the same edge; back-to-back memory ops SHALL stay in ACCESS with mem_req continuously high.
REQ-032 Stores SHALL force wb_rd_write_enable=0 on completion.
REQ-033 mem_be: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0]; mem_wdata: word rt, half {2{rt[15:0]}}, byte {4{rt[7:0]}}.
REQ-034 Load extraction: lane selected by addr[1:0]; extension per dmem_type.
REQ-035 mem_req SHALL be 0 in IDLE; mem_ready in IDLE SHALL be ignored.

Reset
REQ-036 reset SHALL force state IDLE and every output register (wb_*, request registers, align_error) to 0 immediately.
REQ-037 Reset during ACCESS SHALL abandon the request; mem_req SHALL drop to 0 asynchronously.

Configuration
REQ-038 Macro MEM_ALIGN_CHECK_EN selects alignment checking.
REQ-039 Undefined: addr low bits ignored where illegal (word uses aligned word, half ignores addr[0]); align_error tied 0.
REQ-040 Defined: word with addr[1:0]!=0 or half with addr[0]=1 SHALL issue no mem_req, stay IDLE, write wb_* as bubble, and pulse align_error for one cycle.

Verification
REQ-041 Non-memory op, alu_result_in=0x12345678, rd 5, we=1 -> next edge wb_alu_result=0x12345678, wb_rd_write_enable=1, stall_out=0.
REQ-042 Byte load addr 0x1003 type 10, mem_rdata=0x80FFFFFF, mem_ready after 3 cycles -> stall_out=1 for 3 cycles, mem_be=1000, wb_mem_data=0xFFFFFF80.
REQ-043 Half store addr 0x2002, rt=0xAAAA1234, mem_ready immediate -> mem_be=1100, mem_wdata=0x12341234, wb_rd_write_enable=0.
REQ-044 Two back-to-back word loads, mem_ready=1 each cycle -> mem_req high two cycles, both results written in order.
REQ-045 Reset asserted mid-ACCESS -> mem_req=0 and all wb_* 0 without a clock edge.
REQ-046 With MEM_ALIGN_CHECK_EN, word load addr 0x0002 -> no mem_req, align_error one cycle, wb_rd_write_enable=0.
